// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding and frame constants.
package uart_pkg;

    localparam int UART_DATA_BITS            = 8;
    localparam int UART_DEFAULT_CLKS_PER_BIT = 434;

    typedef enum logic [1:0] {
        UART_RX_IDLE  = 2'd0,
        UART_RX_START = 2'd1,
        UART_RX_DATA  = 2'd2,
        UART_RX_STOP  = 2'd3
    } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_monitor_if.sv
// Byte stream leaving the UART receiver towards its consumer.
interface uart_rx_monitor_if;
    import uart_pkg::*;

    // valid/ready: the producer holds data stable while valid is high; a byte
    // transfers on every rising edge where valid && ready; ready may stay high.
    logic [UART_DATA_BITS-1:0] data;
    logic                      valid;
    logic                      ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/uart_rx_fifo.sv
// Show-ahead synchronous FIFO; a push while full is accepted only with a pop.
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    // Head reads as zero while empty so the output is defined out of reset.
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && (!full_o || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart_rx_monitor.sv
// 8N1 UART receiver: synchronizer, mid-bit sampling FSM, byte FIFO, error flags.
module uart_rx_monitor
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clock,
    input  logic                          resetn,
    input  logic                          rxd,
    uart_rx_monitor_if.master             rx_if,
    output logic                          frame_err_o,
    output logic                          overrun_o,
    output logic                          busy_o,
    output uart_rx_state_t                state_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [1:0] ST_IDLE  = UART_RX_IDLE;
    localparam logic [1:0] ST_START = UART_RX_START;
    localparam logic [1:0] ST_DATA  = UART_RX_DATA;
    localparam logic [1:0] ST_STOP  = UART_RX_STOP;

    logic                      s1_q, s1_d;
    logic                      s2_q, s2_d;
    logic                      s3_q, s3_d;
    logic [1:0]                state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [2:0]                idx_q, idx_d;
    logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
    logic                      frame_err_q, frame_err_d;
    logic                      overrun_q, overrun_d;

    logic                      push;
    logic                      pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      fall_edge;
    logic [UART_DATA_BITS-1:0] fifo_rdata;

    assign fall_edge = s3_q && !s2_q;
    assign pop       = rx_if.valid && rx_if.ready;

    always_comb begin
        s1_d        = rxd;
        s2_d        = s1_q;
        s3_d        = s2_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shreg_d     = shreg_q;
        push        = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A low line left over from a bad stop bit shows no edge, so it cannot retrigger.
                if (fall_edge) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_HALF_M1) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = s2_q ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_FULL_M1) begin
                    shreg_d = {s2_q, shreg_q[UART_DATA_BITS-1:1]};
                    cnt_d   = '0;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                // Deciding at mid-stop re-arms half a bit early for back-to-back frames.
                if (cnt_q == CNT_FULL_M1) begin
                    push        = s2_q;
                    frame_err_d = !s2_q;
                    state_d     = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        overrun_d = push && fifo_full && !pop;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            s1_q        <= 1'b1;
            s2_q        <= 1'b1;
            s3_q        <= 1'b1;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shreg_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            s3_q        <= s3_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shreg_q     <= shreg_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clock   (clock),
        .resetn  (resetn),
        .push_i  (push),
        .wdata_i (shreg_d),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_level_o)
    );

    assign rx_if.data  = fifo_rdata;
    assign rx_if.valid = !fifo_empty;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign state_o     = uart_rx_state_t'(state_q);

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Bench for uart_rx_monitor: directed frames plus random traffic against a byte-level model.
module tb_uart_rx_monitor;
    import uart_pkg::*;

    localparam int N     = 16;
    localparam int DEPTH = 4;

    logic           clock  = 1'b0;
    logic           resetn = 1'b0;
    logic           rxd    = 1'b1;
    logic           frame_err_o;
    logic           overrun_o;
    logic           busy_o;
    uart_rx_state_t state_o;
    logic [2:0]     fifo_level_o;

    uart_rx_monitor_if rx_if ();

    uart_rx_monitor #(
        .CLKS_PER_BIT (N),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .rxd          (rxd),
        .rx_if        (rx_if),
        .frame_err_o  (frame_err_o),
        .overrun_o    (overrun_o),
        .busy_o       (busy_o),
        .state_o      (state_o),
        .fifo_level_o (fifo_level_o)
    );

    // clock / reset-free free-running counters
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ready driver: 0 = low, 1 = high, 2 = random each cycle
    int ready_mode = 0;
    initial begin
        rx_if.ready = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            rx_if.ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
        end
    end

    // scoreboard: expected bytes in delivery order
    logic [7:0] exp_q[$];
    int rx_cnt   = 0;
    int ferr_cnt = 0;
    int ovr_cnt  = 0;

    always @(negedge clock) begin
        if (resetn) begin
            if (rx_if.valid && rx_if.ready) begin
                rx_cnt++;
                check("byte_pending", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check("rx_byte", 32'(rx_if.data), 32'(exp_q.pop_front()));
            end
            if (frame_err_o) ferr_cnt++;
            if (overrun_o) ovr_cnt++;
        end
    end

    // driver tasks: entered and left 1 time unit after a rising edge
    int frame_p = 0;

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        frame_p = cyc;
        rxd = 1'b0;
        repeat (N) @(posedge clock);
        #1;
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (N) @(posedge clock);
            #1;
        end
        rxd = stop_bit;
        repeat (N) @(posedge clock);
        #1;
    endtask

    // observation window; cycle numbers are relative to the frame's first low sample
    int first_busy, busy_fall, first_valid, vcount, ferr_first, ferr_n, ovr_first;
    logic [7:0] first_data;

    task automatic watch(input int ncyc);
        int c;
        first_busy = -1; busy_fall = -1; first_valid = -1; vcount = 0;
        ferr_first = -1; ferr_n = 0; ovr_first = -1; first_data = 8'h00;
        repeat (ncyc) begin
            @(negedge clock);
            c = cyc - frame_p;
            if (busy_o && first_busy < 0) first_busy = c;
            if (!busy_o && first_busy >= 0 && busy_fall < 0) busy_fall = c;
            if (rx_if.valid) begin
                vcount++;
                if (first_valid < 0) begin
                    first_valid = c;
                    first_data  = rx_if.data;
                end
            end
            if (frame_err_o) begin
                ferr_n++;
                if (ferr_first < 0) ferr_first = c;
            end
            if (overrun_o && ovr_first < 0) ovr_first = c;
        end
    endtask

    localparam int T_DONE = 3 + N / 2 + 9 * N;

    initial begin
        int ferr0, ovr0, rx0, exp_ferr;
        logic [7:0] b;
        logic       ok;

        resetn = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        resetn = 1'b1;
        check("rst_valid", 32'(rx_if.valid), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_ferr", 32'(frame_err_o), 32'd0);
        check("rst_ovr", 32'(overrun_o), 32'd0);
        check("rst_data", 32'(rx_if.data), 32'h00);
        idle(5);

        // single byte with ready held high
        ready_mode = 1;
        idle(2);
        exp_q.push_back(8'hA5);
        fork
            send_frame(8'hA5, 1'b1);
            watch(10 * N);
        join
        check("a5_busy_rise", first_busy, 3);
        check("a5_valid_rise", first_valid, T_DONE);
        check("a5_data", 32'(first_data), 32'hA5);
        check("a5_valid_len", vcount, 1);
        check("a5_no_ferr", ferr_n, 0);
        idle(5);

        // back-to-back frames held in the FIFO, then drained
        ready_mode = 0;
        idle(2);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h55);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h55, 1'b1);
        idle(10);
        check("b2b_level", 32'(fifo_level_o), 32'd3);
        check("b2b_head", 32'(rx_if.data), 32'h00);
        ready_mode = 1;
        watch(8);
        check("b2b_drain_cycles", vcount, 3);
        check("b2b_all_drained", exp_q.size(), 0);
        @(posedge clock);
        #1;

        // short low glitch on an idle line
        rx0 = rx_cnt;
        fork
            begin
                frame_p = cyc;
                rxd = 1'b0;
                repeat (4) @(posedge clock);
                #1;
                rxd = 1'b1;
            end
            watch(30);
        join
        @(posedge clock);
        #1;
        check("glitch_busy_rise", first_busy, 3);
        check("glitch_busy_fall", busy_fall, 3 + N / 2);
        check("glitch_no_valid", vcount, 0);
        check("glitch_no_ferr", ferr_n, 0);

        // framing error, then a good frame after the line recovers
        fork
            send_frame(8'h3C, 1'b0);
            watch(10 * N);
        join
        check("ferr_at", ferr_first, T_DONE);
        check("ferr_once", ferr_n, 1);
        check("ferr_no_valid", vcount, 0);
        idle(20);
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1);
        idle(20);
        check("ferr_recover_rx", rx_cnt - rx0, 1);

        // overrun on the fifth byte with ready low
        ready_mode = 0;
        ovr0 = ovr_cnt;
        idle(2);
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back(8'(i));
            send_frame(8'(i), 1'b1);
        end
        fork
            send_frame(8'h05, 1'b1);
            watch(10 * N);
        join
        idle(5);
        check("ovr_at", ovr_first, T_DONE);
        check("ovr_once", ovr_cnt - ovr0, 1);
        ready_mode = 1;
        idle(10);
        check("ovr_drained", exp_q.size(), 0);

        // reset in the middle of the data bits
        rx0 = rx_cnt;
        rxd = 1'b0;
        repeat (N) @(posedge clock);
        #1;
        for (int i = 0; i < 3; i++) begin
            rxd = i[0];
            repeat (N) @(posedge clock);
            #1;
        end
        rxd = 1'b1;
        resetn = 1'b0;
        @(posedge clock);
        #1;
        resetn = 1'b1;
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_valid", 32'(rx_if.valid), 32'd0);
        idle(20);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        idle(20);
        check("midrst_one_byte", rx_cnt - rx0, 1);

        // random traffic; the model keeps bytes with a high stop bit
        ready_mode = 2;
        ferr0 = ferr_cnt;
        ovr0 = ovr_cnt;
        exp_ferr = 0;
        for (int k = 0; k < 12; k++) begin
            b  = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 3) != 0);
            if (ok) exp_q.push_back(b);
            else exp_ferr++;
            send_frame(b, ok);
            idle(ok ? $urandom_range(0, 6) : $urandom_range(4, 20));
        end
        ready_mode = 1;
        idle(20);
        check("rand_drained", exp_q.size(), 0);
        check("rand_ferr", ferr_cnt - ferr0, exp_ferr);
        check("rand_no_ovr", ovr_cnt - ovr0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
